// File: rtl/sdram_axi_pkg.sv
// sdram_axi_pkg: shared types and constants for the SDRAM AXI burst responder
package sdram_axi_pkg;
  typedef enum logic [2:0] {IDLE, W_DATA, W_WAIT, W_RESP, R_WAIT, R_DATA} state_e;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam int FIFO_DEPTH = 1024;
  localparam int FIFO_NUM_W = $clog2(FIFO_DEPTH);
endpackage

// File: rtl/sdram_axi_r_skid.sv
// sdram_axi_r_skid: 2-entry R channel skid buffer, head entry held stable while stalled
module sdram_axi_r_skid #(
  parameter int W = 19
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic push, pop;
  assign out_valid_o = cnt_q != 2'd0;
  assign in_ready_o  = cnt_q != 2'd2 || out_ready_i;
  assign out_data_o  = head_q;
  assign count_o     = cnt_q;
  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;
  // head only moves on a pop or when filling an empty slot, so it never changes under stall
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q + 2'(push) - 2'(pop);
    if (pop && cnt_q == 2'd2) head_d = tail_q;
    else if (push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) head_d = in_data_i;
    if (push && (cnt_q == 2'd2 || (cnt_q == 2'd1 && !pop))) tail_d = in_data_i;
  end
  // storage and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/sdram_axi_burst_responder.sv
// sdram_axi_burst_responder: AXI4 slave serialising one burst at a time onto the SDRAM FIFO core
module sdram_axi_burst_responder
  import sdram_axi_pkg::*;
#(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_n_i,
  input  logic [ID_W-1:0]       s_awid_i,
  input  logic [ADDR_W-1:0]     s_awaddr_i,
  input  logic [7:0]            s_awlen_i,
  input  logic [1:0]            s_awburst_i,
  input  logic                  s_awvalid_i,
  output logic                  s_awready_o,
  input  logic [DATA_W-1:0]     s_wdata_i,
  input  logic                  s_wlast_i,
  input  logic                  s_wvalid_i,
  output logic                  s_wready_o,
  output logic [ID_W-1:0]       s_bid_o,
  output logic [1:0]            s_bresp_o,
  output logic                  s_bvalid_o,
  input  logic                  s_bready_i,
  input  logic [ID_W-1:0]       s_arid_i,
  input  logic [ADDR_W-1:0]     s_araddr_i,
  input  logic [7:0]            s_arlen_i,
  input  logic [1:0]            s_arburst_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [ID_W-1:0]       s_rid_o,
  output logic [DATA_W-1:0]     s_rdata_o,
  output logic [1:0]            s_rresp_o,
  output logic                  s_rlast_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i,
  output logic                  wr_fifo_wr_req_o,
  output logic [DATA_W-1:0]     wr_fifo_wr_data_o,
  input  logic [FIFO_NUM_W-1:0] wr_fifo_num_i,
  output logic [ADDR_W-1:0]     wr_b_addr_o,
  output logic [ADDR_W-1:0]     wr_e_addr_o,
  output logic [7:0]            wr_len_o,
  output logic                  wr_burst_flag_o,
  input  logic                  sdram_wr_end_i,
  output logic [ADDR_W-1:0]     rd_b_addr_o,
  output logic [ADDR_W-1:0]     rd_e_addr_o,
  output logic [7:0]            rd_len_o,
  output logic                  rd_burst_flag_o,
  output logic                  rd_fifo_rd_req_o,
  input  logic [DATA_W-1:0]     rd_fifo_rd_data_i,
  input  logic [FIFO_NUM_W-1:0] rd_fifo_num_i,
  input  logic                  sdram_rd_end_i
);
  localparam int SK_W = DATA_W + 3;
  state_e state_q, state_d;
  logic live_q, rr_q, rr_d, err_q, err_d, discard_q, discard_d, pend_q, pend_last_q;
  logic [ID_W-1:0] id_q, id_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d, e_addr_q, e_addr_d;
  logic [7:0] len_q, len_d, beat_q, beat_d;
  logic [8:0] issue_q, issue_d;
  logic idle_rdy, aw_hs, ar_hs, w_hs, issue_left, r_fire;
  logic sk_in_valid, sk_in_ready, sk_out_valid;
  logic [SK_W-1:0] sk_in_data, sk_out_data;
  logic [1:0] sk_cnt;
  // live_q keeps both address readies low while reset is asserted
  assign idle_rdy    = live_q && state_q == IDLE;
  assign s_awready_o = idle_rdy && (!s_arvalid_i || !rr_q);
  assign s_arready_o = idle_rdy && (!s_awvalid_i || rr_q);
  assign aw_hs       = s_awvalid_i && s_awready_o;
  assign ar_hs       = s_arvalid_i && s_arready_o;
  assign s_wready_o  = state_q == W_DATA && wr_fifo_num_i <= FIFO_NUM_W'(FIFO_DEPTH - 2);
  assign w_hs        = s_wvalid_i && s_wready_o;
  assign wr_fifo_wr_req_o  = w_hs && !discard_q;
  assign wr_fifo_wr_data_o = wr_fifo_wr_req_o ? s_wdata_i : '0;
  assign wr_burst_flag_o   = state_q == W_WAIT;
  assign rd_burst_flag_o   = state_q == R_WAIT;
  assign s_bvalid_o  = state_q == W_RESP;
  assign s_bresp_o   = s_bvalid_o && err_q ? RESP_SLVERR : RESP_OKAY;
  assign s_bid_o     = id_q;
  assign s_rid_o     = id_q;
  assign wr_b_addr_o = b_addr_q;
  assign wr_e_addr_o = e_addr_q;
  assign wr_len_o    = len_q;
  assign rd_b_addr_o = b_addr_q;
  assign rd_e_addr_o = e_addr_q;
  assign rd_len_o    = len_q;
  // pops are credited against skid occupancy plus the one pop whose data is still in flight
  assign issue_left  = issue_q <= {1'b0, len_q};
  assign r_fire      = sk_out_valid && s_rready_i;
  assign rd_fifo_rd_req_o = state_q == R_DATA && !discard_q && issue_left && rd_fifo_num_i != '0 &&
                            (sk_cnt + {1'b0, pend_q} < 2'd2 || r_fire);
  assign sk_in_valid = state_q == R_DATA && (discard_q ? issue_left : pend_q);
  assign sk_in_data  = discard_q ? {RESP_SLVERR, issue_q[7:0] == len_q, {DATA_W{1'b0}}}
                                 : {RESP_OKAY, pend_last_q, rd_fifo_rd_data_i};
  assign s_rvalid_o  = sk_out_valid;
  assign s_rdata_o   = sk_out_data[DATA_W-1:0];
  assign s_rlast_o   = sk_out_valid && sk_out_data[DATA_W];
  assign s_rresp_o   = sk_out_valid ? sk_out_data[DATA_W+2:DATA_W+1] : RESP_OKAY;
  sdram_axi_r_skid #(.W(SK_W)) u_skid (
    .clk_i       (sys_clk_i),
    .rst_ni      (sys_rst_n_i),
    .in_valid_i  (sk_in_valid),
    .in_ready_o  (sk_in_ready),
    .in_data_i   (sk_in_data),
    .out_valid_o (sk_out_valid),
    .out_ready_i (s_rready_i),
    .out_data_o  (sk_out_data),
    .count_o     (sk_cnt)
  );
  // next-state: latch the granted request, count beats, walk the transaction phases
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    err_d     = err_q;
    discard_d = discard_q;
    id_d      = id_q;
    b_addr_d  = b_addr_q;
    e_addr_d  = e_addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    issue_d   = issue_q + 9'(discard_q ? sk_in_valid && sk_in_ready : rd_fifo_rd_req_o);
    if (aw_hs || ar_hs) begin
      id_d      = aw_hs ? s_awid_i : s_arid_i;
      b_addr_d  = aw_hs ? s_awaddr_i : s_araddr_i;
      len_d     = aw_hs ? s_awlen_i : s_arlen_i;
      e_addr_d  = b_addr_d + ADDR_W'(len_d) + ADDR_W'(1);
      discard_d = (aw_hs ? s_awburst_i : s_arburst_i) != BURST_INCR;
      err_d     = discard_d;
      beat_d    = '0;
      issue_d   = '0;
      rr_d      = s_awvalid_i && s_arvalid_i ? !rr_q : rr_q;
      state_d   = aw_hs ? W_DATA : discard_d ? R_DATA : R_WAIT;
    end
    case (state_q)
      W_DATA: if (w_hs) begin
        beat_d = beat_q + 8'd1;
        if ((beat_q == len_q) != s_wlast_i) err_d = 1'b1;
        if (beat_q == len_q) state_d = discard_q ? W_RESP : W_WAIT;
      end
      W_WAIT: if (sdram_wr_end_i) state_d = W_RESP;
      W_RESP: if (s_bready_i) state_d = IDLE;
      R_WAIT: if (sdram_rd_end_i) state_d = R_DATA;
      R_DATA: if (r_fire && s_rlast_o) state_d = IDLE;
      default: ;
    endcase
  end
  // transaction state registers
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q     <= IDLE;
      live_q      <= 1'b0;
      rr_q        <= 1'b0;
      err_q       <= 1'b0;
      discard_q   <= 1'b0;
      id_q        <= '0;
      b_addr_q    <= '0;
      e_addr_q    <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      issue_q     <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      rr_q        <= rr_d;
      err_q       <= err_d;
      discard_q   <= discard_d;
      id_q        <= id_d;
      b_addr_q    <= b_addr_d;
      e_addr_q    <= e_addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      issue_q     <= issue_d;
      pend_q      <= rd_fifo_rd_req_o;
      pend_last_q <= rd_fifo_rd_req_o && issue_q[7:0] == len_q;
    end
  end
endmodule
